// File: rtl/pc_sequencer.sv
// Registered program counter with increment / jump / relative-branch / return
// selection and a circular return-address stack for call/return.
module pc_sequencer #(
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        DISP_W      = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int unsigned        STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic [1:0]                    pc_sel,
  input  logic                          call,
  input  logic [ADDR_W-1:0]             target,
  input  logic [DISP_W-1:0]             disp,
  input  logic                          flag_clr,
  output logic [ADDR_W-1:0]             pc,
  output logic [ADDR_W-1:0]             pc_next,
  output logic [$clog2(STACK_DEPTH):0]  depth,
  output logic                          stk_empty,
  output logic                          stk_full,
  output logic                          ovf,
  output logic                          unf
);

  localparam int unsigned       PTR_W    = $clog2(STACK_DEPTH);
  localparam int unsigned       CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    SEL_INC = 2'b00,
    SEL_JMP = 2'b01,
    SEL_REL = 2'b10,
    SEL_RET = 2'b11
  } sel_e;

  sel_e              sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] rel_tgt;
  logic [ADDR_W-1:0] tos;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  depth_q;
  logic              ovf_q;
  logic              unf_q;
  logic              is_empty;
  logic              is_full;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;
  logic              unf_evt;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  assign sel      = sel_e'(pc_sel);
  assign disp_ext = ADDR_W'($signed(disp));
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == FULL_CNT);

  // wr_ptr names the next free slot; when full it also names the oldest
  // entry, so a push while full overwrites it without extra bookkeeping.
  always_comb begin
    pc_inc  = pc_q + ADDR_W'(1);
    rel_tgt = pc_q + disp_ext;
    top_ptr = wr_ptr - PTR_W'(1);
    tos     = stack_mem[top_ptr];

    do_push = !stall && call && ((sel == SEL_JMP) || (sel == SEL_REL));
    do_pop  = !stall && (sel == SEL_RET) && !is_empty;
    ovf_evt = do_push && is_full;
    unf_evt = !stall && (sel == SEL_RET) && is_empty;

    pc_next = pc_inc;
    if (stall) begin
      pc_next = pc_q;
    end else begin
      unique case (sel)
        SEL_INC: pc_next = pc_inc;
        SEL_JMP: pc_next = target;
        SEL_REL: pc_next = rel_tgt;
        SEL_RET: pc_next = is_empty ? pc_inc : tos;
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      wr_ptr  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!is_full) depth_q <= depth_q + CNT_W'(1);
      end else if (do_pop) begin
        wr_ptr  <= top_ptr;
        depth_q <= depth_q - CNT_W'(1);
      end
      // A same-cycle overflow/underflow beats flag_clr.
      ovf_q <= ovf_evt | (ovf_q & ~flag_clr);
      unf_q <= unf_evt | (unf_q & ~flag_clr);
    end
  end

  // Stack storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[wr_ptr] <= pc_inc;
  end

  assign pc        = pc_q;
  assign depth     = depth_q;
  assign stk_empty = is_empty;
  assign stk_full  = is_full;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: expected state per step is queued when the
// step is driven and compared after the clock edge that consumes it.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        call;
  logic [15:0] target;
  logic [7:0]  disp;
  logic        flag_clr;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [2:0]  depth;
  logic        stk_empty;
  logic        stk_full;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
  } obs_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  sel;
    logic        call;
    logic [15:0] target;
    logic [7:0]  disp;
    logic        fclr;
    logic [15:0] pc;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
  } step_t;

  obs_t exp_q[$];
  obs_t got;
  assign got = {pc, depth, ovf, unf};

  pc_sequencer #(
    .ADDR_W      (16),
    .DISP_W      (8),
    .RESET_PC    (16'h0100),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .pc_sel    (pc_sel),
    .call      (call),
    .target    (target),
    .disp      (disp),
    .flag_clr  (flag_clr),
    .pc        (pc),
    .pc_next   (pc_next),
    .depth     (depth),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input step_t s);
    stall    = s.stall;
    pc_sel   = s.sel;
    call     = s.call;
    target   = s.target;
    disp     = s.disp;
    flag_clr = s.fclr;
  endtask

  task automatic apply(input step_t s);
    drive(s);
    exp_q.push_back({s.pc, s.depth, s.ovf, s.unf});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step_t tbl [3];
    obs_t  e;
    tbl = '{
      '{1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0101, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0102, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0103, 3'd0, 1'b0, 1'b0}
    };
    rst_n = 1'b0;
    drive(tbl[0]);
    pc_sel = 2'b01;
    call   = 1'b1;
    target = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pc, depth, ovf, unf, stk_empty, stk_full} !== {16'h0100, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state pc=%h depth=%0d ovf=%b unf=%b empty=%b full=%b exp pc=0100 depth=0 ovf=0 unf=0 empty=1 full=0",
               pc, depth, ovf, unf, stk_empty, stk_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[0]);
    #1;
    checks++;
    if (pc_next !== 16'h0101) begin
      errors++;
      $display("FAIL reset_pc_next got %h exp 0101", pc_next);
    end
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL increment[%0d] pc/depth/ovf/unf got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                 i, got.pc, got.depth, got.ovf, got.unf, e.pc, e.depth, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_branch;
    step_t tbl [7];
    obs_t  e;
    tbl = '{
      '{1'b0, 2'b01, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0010, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b10, 1'b0, 16'h0000, 8'hF0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b10, 1'b0, 16'h0000, 8'h80, 1'b0, 16'hFF80, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b10, 1'b0, 16'h0000, 8'h05, 1'b0, 16'hFF85, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b10, 1'b0, 16'h0000, 8'h00, 1'b0, 16'hFF85, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b0, 16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      if (i == 1) begin
        drive(tbl[i]);
        #1;
        checks++;
        if (pc_next !== 16'h0000) begin
          errors++;
          $display("FAIL rel_pc_next got %h exp 0000", pc_next);
        end
      end
      apply(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL branch[%0d] pc/depth/ovf/unf got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                 i, got.pc, got.depth, got.ovf, got.unf, e.pc, e.depth, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_call_return;
    step_t tbl [6];
    obs_t  e;
    tbl = '{
      '{1'b0, 2'b01, 1'b0, 16'h0020, 8'h00, 1'b0, 16'h0020, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h0400, 8'h00, 1'b0, 16'h0400, 3'd1, 1'b0, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0021, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b00, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h0022, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b10, 1'b1, 16'h0000, 8'h10, 1'b0, 16'h0032, 3'd1, 1'b0, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0023, 3'd0, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL call_return[%0d] pc/depth/ovf/unf got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                 i, got.pc, got.depth, got.ovf, got.unf, e.pc, e.depth, e.ovf, e.unf);
      end
    end
    checks++;
    if ({stk_empty, stk_full} !== 2'b10) begin
      errors++;
      $display("FAIL call_return_empty empty/full got %b/%b exp 1/0", stk_empty, stk_full);
    end
  endtask

  task automatic test_overflow;
    step_t tbl [11];
    obs_t  e;
    tbl = '{
      '{1'b0, 2'b01, 1'b0, 16'h1000, 8'h00, 1'b0, 16'h1000, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h2000, 8'h00, 1'b0, 16'h2000, 3'd1, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h3000, 8'h00, 1'b0, 16'h3000, 3'd2, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h4000, 8'h00, 1'b0, 16'h4000, 3'd3, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h5000, 8'h00, 1'b0, 16'h5000, 3'd4, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h6000, 8'h00, 1'b0, 16'h6000, 3'd4, 1'b1, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h5001, 3'd3, 1'b1, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h4001, 3'd2, 1'b1, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h3001, 3'd1, 1'b1, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h2001, 3'd0, 1'b1, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h2002, 3'd0, 1'b1, 1'b1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL overflow[%0d] pc/depth/ovf/unf got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                 i, got.pc, got.depth, got.ovf, got.unf, e.pc, e.depth, e.ovf, e.unf);
      end
      if (i == 5) begin
        checks++;
        if ({stk_empty, stk_full} !== 2'b01) begin
          errors++;
          $display("FAIL overflow_full empty/full got %b/%b exp 0/1", stk_empty, stk_full);
        end
      end
    end
  endtask

  task automatic test_stall;
    step_t tbl [10];
    obs_t  e;
    tbl = '{
      '{1'b1, 2'b01, 1'b1, 16'h7000, 8'h00, 1'b0, 16'h2002, 3'd0, 1'b1, 1'b1},
      '{1'b1, 2'b01, 1'b1, 16'h7000, 8'h00, 1'b0, 16'h2002, 3'd0, 1'b1, 1'b1},
      '{1'b1, 2'b01, 1'b1, 16'h7000, 8'h00, 1'b0, 16'h2002, 3'd0, 1'b1, 1'b1},
      '{1'b1, 2'b01, 1'b1, 16'h7000, 8'h00, 1'b1, 16'h2002, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h2003, 3'd0, 1'b0, 1'b1},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h2004, 3'd0, 1'b0, 1'b1},
      '{1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h2005, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h3000, 8'h00, 1'b0, 16'h3000, 3'd1, 1'b0, 1'b0},
      '{1'b1, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h3000, 3'd1, 1'b0, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h2006, 3'd0, 1'b0, 1'b0}
    };
    drive(tbl[0]);
    #1;
    checks++;
    if (pc_next !== 16'h2002) begin
      errors++;
      $display("FAIL stall_pc_next got %h exp 2002", pc_next);
    end
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stall[%0d] pc/depth/ovf/unf got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                 i, got.pc, got.depth, got.ovf, got.unf, e.pc, e.depth, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_async_reset;
    step_t tbl [4];
    obs_t  e;
    tbl = '{
      '{1'b0, 2'b01, 1'b1, 16'h0100, 8'h00, 1'b0, 16'h0100, 3'd1, 1'b0, 1'b0},
      '{1'b0, 2'b01, 1'b1, 16'h0200, 8'h00, 1'b0, 16'h0200, 3'd2, 1'b0, 1'b0},
      '{1'b0, 2'b00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0101, 3'd0, 1'b0, 1'b0},
      '{1'b0, 2'b11, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0102, 3'd0, 1'b0, 1'b1}
    };
    foreach (tbl[i]) begin
      if (i == 2) begin
        drive(tbl[1]);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, depth, stk_empty, stk_full} !== {16'h0100, 3'd0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL async_reset pc=%h depth=%0d empty=%b full=%b exp pc=0100 depth=0 empty=1 full=0",
                   pc, depth, stk_empty, stk_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      apply(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL async_reset_seq[%0d] pc/depth/ovf/unf got %h/%0d/%b/%b exp %h/%0d/%b/%b",
                 i, got.pc, got.depth, got.ovf, got.unf, e.pc, e.depth, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    pc_sel   = 2'b00;
    call     = 1'b0;
    target   = '0;
    disp     = '0;
    flag_clr = 1'b0;
    test_reset();
    test_branch();
    test_call_return();
    test_overflow();
    test_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
